key_start_gen: RTL and testbench

//   Conditions the raw push-button for the SPI master test top and produces the

---
 rtl/key_start_gen.sv | 110 +++++++++++
 tb/tb_key_start_gen.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/key_start_gen.sv
// Push-button conditioner for the SPI master test top.
// Synchronises, debounces and edge-detects the key, then issues start requests.
module key_start_gen #(
  parameter int TICK_DIV     = 27000,
  parameter int STABLE_TICKS = 5,
  parameter int DATA_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0] DATA_INIT = DATA_WIDTH'(8'hFF)
) (
  input  logic                  I_CLK,
  input  logic                  I_RESETN,
  input  logic                  I_KEY,
  input  logic                  I_BUSY,
  output logic                  O_START,
  output logic [DATA_WIDTH-1:0] O_DATA,
  output logic                  O_PENDING,
  output logic                  O_KEY_LVL,
  output logic                  O_DROP
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  typedef enum logic {
    RELEASED = 1'b0,
    PRESSED  = 1'b1
  } state_t;

  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    sync1_q, sync2_q;
  logic [STABLE_TICKS-1:0] hist_q, hist_d;
  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    pend_q, pend_d;
  logic                    start_q, start_d;
  logic                    drop_q, drop_d;
  logic                    tick;
  logic                    press_evt;
  logic                    issue;

  assign tick = (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d     = tick ? '0 : cnt_q + CW'(1);
    hist_d    = hist_q;
    state_d   = state_q;
    press_evt = 1'b0;
    if (tick) begin
      hist_d[0] = sync2_q;
      for (int i = 1; i < STABLE_TICKS; i++)
        hist_d[i] = hist_q[i-1];
      unique case (1'b1)
        (state_q == RELEASED) && (hist_d == '0): begin
          state_d   = PRESSED;
          press_evt = 1'b1;
        end
        (state_q == PRESSED) && (hist_d == '1): begin
          state_d = RELEASED;
        end
        default: ;
      endcase
    end
  end

  // Press and issue never collide: a press is accepted only with no
  // request pending, and issue only happens with one pending.
  always_comb begin
    issue   = pend_q && !I_BUSY && !start_q;
    start_d = issue;
    drop_d  = press_evt && pend_q;
    pend_d  = pend_q;
    data_d  = data_q;
    if (press_evt && !pend_q) begin
      pend_d = 1'b1;
      data_d = data_q - DATA_WIDTH'(1);
    end else if (issue) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge I_CLK or negedge I_RESETN) begin
    if (!I_RESETN) begin
      cnt_q   <= '0;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= '1;
      state_q <= RELEASED;
      data_q  <= DATA_INIT;
      pend_q  <= 1'b0;
      start_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sync1_q <= I_KEY;
      sync2_q <= sync1_q;
      hist_q  <= hist_d;
      state_q <= state_d;
      data_q  <= data_d;
      pend_q  <= pend_d;
      start_q <= start_d;
      drop_q  <= drop_d;
    end
  end

  assign O_START   = start_q;
  assign O_DATA    = data_q;
  assign O_PENDING = pend_q;
  assign O_KEY_LVL = (state_q == PRESSED);
  assign O_DROP    = drop_q;

endmodule

// File: tb/tb_key_start_gen.sv
// Directed bench for key_start_gen with a fast tick.
// Monitor counts start/drop pulses; checks use immediate assertions.
module tb_key_start_gen;

  logic       clk;
  logic       rst_n;
  logic       key;
  logic       busy;
  logic       start;
  logic [7:0] data;
  logic       pend;
  logic       lvl;
  logic       drop;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int drop_cnt = 0;
  int dbl_cnt = 0;
  logic [7:0] start_data = 8'h00;
  logic prev_start = 1'b0;
  int base;

  key_start_gen #(
    .TICK_DIV    (4),
    .STABLE_TICKS(5),
    .DATA_WIDTH  (8),
    .DATA_INIT   (8'hFF)
  ) dut (
    .I_CLK    (clk),
    .I_RESETN (rst_n),
    .I_KEY    (key),
    .I_BUSY   (busy),
    .O_START  (start),
    .O_DATA   (data),
    .O_PENDING(pend),
    .O_KEY_LVL(lvl),
    .O_DROP   (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (start) begin
      start_cnt = start_cnt + 1;
      start_data = data;
      if (prev_start) dbl_cnt = dbl_cnt + 1;
    end
    if (drop) drop_cnt = drop_cnt + 1;
    prev_start = start;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    key   = 1'b1;
    busy  = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
  endtask

  task automatic press(input int lo, input int hi);
    key = 1'b0;
    cyc(lo);
    key = 1'b1;
    cyc(hi);
  endtask

  initial begin
    rst_n = 1'b0;
    key   = 1'b1;
    busy  = 1'b0;
    cyc(3);
    check("rst_start", 32'(start), 32'h0);
    check("rst_data", 32'(data), 32'hFF);
    check("rst_pend", 32'(pend), 32'h0);
    check("rst_lvl", 32'(lvl), 32'h0);
    check("rst_drop", 32'(drop), 32'h0);

    // 1: idle key
    rst_n = 1'b1;
    cyc(100);
    check("idle_starts", 32'(start_cnt), 32'd0);
    check("idle_drops", 32'(drop_cnt), 32'd0);
    check("idle_lvl", 32'(lvl), 32'h0);
    check("idle_data", 32'(data), 32'hFF);

    // 2: bouncy press then steady low
    for (int i = 0; i < 30; i++) begin
      key = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
      cyc(1);
    end
    check("bounce_starts", 32'(start_cnt), 32'd0);
    key = 1'b0;
    cyc(40);
    check("press_starts", 32'(start_cnt), 32'd1);
    check("press_sdata", 32'(start_data), 32'hFE);
    check("press_lvl", 32'(lvl), 32'h1);
    key = 1'b1;
    cyc(40);
    check("rel_lvl", 32'(lvl), 32'h0);
    check("rel_starts", 32'(start_cnt), 32'd1);

    // 3: busy holds request, second press dropped
    do_reset();
    base = start_cnt;
    busy = 1'b1;
    press(30, 30);
    check("busy_pend", 32'(pend), 32'h1);
    check("busy_data", 32'(data), 32'hFE);
    check("busy_starts", 32'(start_cnt - base), 32'd0);
    press(30, 30);
    check("drop_cnt", 32'(drop_cnt), 32'd1);
    check("drop_data", 32'(data), 32'hFE);
    check("drop_pend", 32'(pend), 32'h1);
    busy = 1'b0;
    cyc(5);
    check("unbusy_starts", 32'(start_cnt - base), 32'd1);
    check("unbusy_sdata", 32'(start_data), 32'hFE);
    check("unbusy_pend", 32'(pend), 32'h0);

    // 4: count down to zero, then wrap
    do_reset();
    base = start_cnt;
    for (int i = 0; i < 255; i++) press(28, 28);
    check("cnt_data", 32'(data), 32'h00);
    check("cnt_starts", 32'(start_cnt - base), 32'd255);
    press(28, 28);
    check("wrap_data", 32'(data), 32'hFF);
    check("wrap_sdata", 32'(start_data), 32'hFF);

    // 5: reset while a request waits on busy
    do_reset();
    base = start_cnt;
    busy = 1'b1;
    press(30, 30);
    check("pre_rst_pend", 32'(pend), 32'h1);
    rst_n = 1'b0;
    cyc(1);
    check("mid_rst_pend", 32'(pend), 32'h0);
    check("mid_rst_data", 32'(data), 32'hFF);
    busy = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(50);
    check("post_rst_starts", 32'(start_cnt - base), 32'd0);
    check("post_rst_pend", 32'(pend), 32'h0);

    // 6: three long holds
    do_reset();
    base = start_cnt;
    for (int i = 0; i < 3; i++) press(200, 200);
    check("hold_starts", 32'(start_cnt - base), 32'd3);
    check("hold_data", 32'(data), 32'hFC);
    check("hold_sdata", 32'(start_data), 32'hFC);
    check("single_cycle", 32'(dbl_cnt), 32'd0);
    check("total_drops", 32'(drop_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
